// File: rtl/frame_pkg.sv
// Shared definitions for the double-buffered SRAM frame store.
// Holds the frame geometry, the SRAM word-address field layout, the palette
// index type and the next-frame writer state encoding.
package frame_pkg;

  // Frame geometry: four 4-bit pixels are packed into each 16-bit SRAM word.
  localparam int H_WORDS      = 160;
  localparam int FRAME_ROWS   = 480;
  localparam int PIX_PER_WORD = 4;

  // SRAM word address layout: [19]=0, [18]=buffer, [17:8]=row, [7:0]=word column.
  localparam int ADDR_W  = 20;
  localparam int WORD_W  = 16;
  localparam int BUF_BIT = 18;
  localparam int ROW_LSB = 8;
  localparam int ROW_W   = BUF_BIT - ROW_LSB;  // 10 bits of row
  localparam int COL_W   = ROW_LSB;            // 8 bits of word column

  typedef logic [3:0] color_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_CLR     = 3'd4
  } wr_state_t;

  // Word address of (buffer, row, word column) in the frame store.
  function automatic logic [ADDR_W-1:0] frame_addr(
    input logic             buf_sel,
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [ADDR_W-1:0] a;
    a                    = '0;
    a[BUF_BIT]           = buf_sel;
    a[ROW_LSB +: ROW_W]  = row;
    a[COL_W-1:0]         = col;
    return a;
  endfunction

  // Word column holding pixel column x.
  function automatic logic [COL_W-1:0] pix_word_col(input logic [9:0] x);
    return x[9:2];
  endfunction

  // Nibble lane of pixel column x inside its word.
  function automatic logic [1:0] pix_lane(input logic [9:0] x);
    return x[1:0];
  endfunction

endpackage

// File: rtl/nibble_merge.sv
// Replaces one 4-bit pixel lane of a 16-bit frame-store word with a new colour.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: i_word (original word), i_idx (lane 0..3, lane p = bits [4p+3:4p]),
//        i_color (new palette index), o_word (merged word).
module nibble_merge
  import frame_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_idx,
  input  color_idx_t        i_color,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    case (i_idx)
      2'd0:    o_word[3:0]   = i_color;
      2'd1:    o_word[7:4]   = i_color;
      2'd2:    o_word[11:8]  = i_color;
      default: o_word[15:12] = i_color;
    endcase
  end

endmodule

// File: rtl/next_frame_writer.sv
// Write engine for the next-frame SRAM buffer: single-pixel read-modify-write
// and bulk clear to BG_COLOR. Latency: pixel write lands 3 granted cycles after
// accept; a clear takes H_WORDS*FRAME_ROWS granted cycles. Backpressure:
// req_ready only in IDLE with SRAM granted and no clear waiting; sram_grant=0
// idles the SRAM controls and freezes progress.
// Ports: Clk/Reset (async active-high); even_frame selects the displayed
// buffer (we write ~even_frame); req_* pixel request handshake; clear_start
// pulse; busy/clear_done/dropped status; SRAM_* and Data_* drive the shared port.
// Optional build macro NEXT_FRAME_TRANSPARENCY_EN: colour index 0 becomes
// transparent (accepted, never written, no dropped pulse).
module next_frame_writer
  import frame_pkg::*;
#(
  parameter int         H_PIXELS = H_WORDS * PIX_PER_WORD,
  parameter int         V_PIXELS = FRAME_ROWS,
  parameter color_idx_t BG_COLOR = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              even_frame,
  input  logic              sram_grant,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  color_idx_t        req_color,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              dropped,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [WORD_W-1:0] Data_to_SRAM,
  input  logic [WORD_W-1:0] Data_from_SRAM
);

  // Range limits sized to the operands they are compared against.
  localparam logic [9:0]       X_LIMIT  = 10'(H_PIXELS);
  localparam logic [9:0]       Y_LIMIT  = 10'(V_PIXELS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_PIXELS / PIX_PER_WORD - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_PIXELS - 1);

  wr_state_t         r_state;
  wr_state_t         w_state_nxt;

  logic              r_clr_pend;
  logic              r_buf;        // buffer bit latched at accept / clear start
  logic [COL_W-1:0]  r_xw;         // latched word column
  logic [1:0]        r_xp;         // latched nibble lane
  logic [ROW_W-1:0]  r_y;
  color_idx_t        r_color;
  logic [WORD_W-1:0] r_word_q;     // word captured in RD_WAIT
  logic [COL_W-1:0]  r_col;        // clear sweep position
  logic [ROW_W-1:0]  r_row;

  logic              w_clr_req;
  logic              w_ready_idle;
  logic              w_accept;
  logic              w_oor;
  logic              w_transparent;
  logic              w_clr_go;
  logic              w_last_clr;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [WORD_W-1:0] w_merged;

  // A clear is wanted if one is already queued or is being requested now;
  // either way it outranks a pixel request in the same cycle.
  assign w_clr_req    = r_clr_pend | clear_start;
  // Reset gates ready so nothing is accepted while reset is held.
  assign w_ready_idle = sram_grant & ~w_clr_req & ~Reset;
  assign w_accept     = (r_state == ST_IDLE) & req_valid & w_ready_idle;
  assign w_clr_go     = (r_state == ST_IDLE) & sram_grant & w_clr_req;
  assign w_oor        = (req_x >= X_LIMIT) | (req_y >= Y_LIMIT);
  assign w_last_clr   = (r_row == LAST_ROW) & (r_col == LAST_COL);

`ifdef NEXT_FRAME_TRANSPARENCY_EN
  assign w_transparent = (req_color == 4'h0);
`else
  assign w_transparent = 1'b0;
`endif

  assign w_pix_addr = frame_addr(r_buf, r_y, r_xw);
  assign w_clr_addr = frame_addr(r_buf, r_row, r_col);

  nibble_merge u_merge (
    .i_word  (r_word_q),
    .i_idx   (r_xp),
    .i_color (r_color),
    .o_word  (w_merged)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  // Every transition needs the grant; without it the FSM holds, except that
  // a read lost in RD_WAIT falls back to RD so the read is issued again.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_go) begin
          w_state_nxt = ST_CLR;
        end else if (w_accept && !w_oor && !w_transparent) begin
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (sram_grant) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_state_nxt = sram_grant ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (sram_grant) w_state_nxt = ST_IDLE;
      end
      ST_CLR: begin
        if (sram_grant && w_last_clr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    req_ready    = 1'b0;
    busy         = (r_state != ST_IDLE) | r_clr_pend;
    clear_done   = 1'b0;
    dropped      = 1'b0;
    SRAM_ADDRESS = '0;
    SRAM_OE_N    = 1'b1;
    SRAM_WE_N    = 1'b1;
    Data_to_SRAM = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_ready_idle;
        dropped   = w_accept & w_oor;
      end
      ST_RD, ST_RD_WAIT: begin
        SRAM_ADDRESS = w_pix_addr;
        SRAM_OE_N    = ~sram_grant;
      end
      ST_WR: begin
        SRAM_ADDRESS = w_pix_addr;
        SRAM_WE_N    = ~sram_grant;
        Data_to_SRAM = w_merged;
      end
      ST_CLR: begin
        SRAM_ADDRESS = w_clr_addr;
        SRAM_WE_N    = ~sram_grant;
        Data_to_SRAM = {4{BG_COLOR}};
        clear_done   = sram_grant & w_last_clr;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clr_pend <= 1'b0;
      r_buf      <= 1'b0;
      r_xw       <= '0;
      r_xp       <= '0;
      r_y        <= '0;
      r_color    <= '0;
      r_word_q   <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      // Pending flag: consumed when the clear launches; a pulse that arrives
      // mid-clear is meaningless and is not queued.
      if (w_clr_go) begin
        r_clr_pend <= 1'b0;
      end else if (clear_start && (r_state != ST_CLR)) begin
        r_clr_pend <= 1'b1;
      end

      if (w_accept) begin
        r_buf   <= ~even_frame;
        r_xw    <= pix_word_col(req_x);
        r_xp    <= pix_lane(req_x);
        r_y     <= req_y;
        r_color <= req_color;
      end

      if (w_clr_go) begin
        r_buf <= ~even_frame;
        r_col <= '0;
        r_row <= '0;
      end else if ((r_state == ST_CLR) && sram_grant) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if ((r_state == ST_RD_WAIT) && sram_grant) begin
        r_word_q <= Data_from_SRAM;
      end
    end
  end

endmodule
